// File: rtl/conv_encoder_tx_pkg.sv
// conv_pkg: shared definitions for the rate-1/2 convolutional code.
// Used by conv_encoder_tx (transmit) and the Viterbi decoder (branch
// metrics), so both ends agree on generators and symbol bit order.
//   K_DEF, G0_DEF, G1_DEF : default constraint length and generators
//   K_MAX                 : widest window conv_sym() accepts
//   enc_state_t           : encoder frame FSM states
//   conv_sym()            : {G0 parity, G1 parity} of a K-bit window
package conv_pkg;

  localparam int             K_DEF       = 3;
  localparam logic [2:0]     G0_DEF      = 3'b111;  // octal 7
  localparam logic [2:0]     G1_DEF      = 3'b101;  // octal 5
  localparam int             MAX_LEN_DEF = 256;
  localparam int             K_MAX       = 16;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL
  } enc_state_t;

  // Window and generators are zero-extended to K_MAX by the caller, so the
  // upper bits never contribute to either parity.
  function automatic logic [1:0] conv_sym(input logic [K_MAX-1:0] w,
                                          input logic [K_MAX-1:0] g0,
                                          input logic [K_MAX-1:0] g1);
    return {^(w & g0), ^(w & g1)};
  endfunction

endpackage

// File: rtl/conv_encoder_tx_if.sv
// conv_encoder_tx_if: input bit stream and output symbol stream of the
// encoder, both ready/valid.
//   in_valid/in_ready/in_bit/in_last     : data bits, in_last ends a frame
//   out_valid/out_ready/out_sym/out_last : code symbols, out_last on the
//                                          final tail symbol of a frame
// Modports: slave = encoder side, master = the producer/consumer around it.
interface conv_encoder_tx_if;

  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_sym;
  logic       out_last;

  modport slave (
    input  in_valid, in_bit, in_last, out_ready,
    output in_ready, out_valid, out_sym, out_last
  );

  modport master (
    output in_valid, in_bit, in_last, out_ready,
    input  in_ready, out_valid, out_sym, out_last
  );

endinterface

// File: rtl/conv_enc_core.sv
// conv_enc_core: K-1 bit shift state plus combinational symbol for the
// current input bit.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear of the shift state (frame boundary)
//   load     : shift b into the state this cycle
//   b        : bit being encoded (0 during tail)
//   sym      : {G0 parity, G1 parity} of the window {b, s}
module conv_enc_core
  import conv_pkg::*;
#(
  parameter int           K  = K_DEF,
  parameter logic [K-1:0] G0 = G0_DEF,
  parameter logic [K-1:0] G1 = G1_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load,
  input  logic       b,
  output logic [1:0] sym
);

  // s[K-2] holds the most recent bit, so the window reads newest-first.
  logic [K-2:0] s;
  logic [K-1:0] w;

  assign w   = {b, s};
  assign sym = conv_sym(K_MAX'(w), K_MAX'(G0), K_MAX'(G1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order processes are evaluated.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      s <= '0;
    end else if (load) begin
      s <= w[K-1:1];
    end
  end

endmodule

// File: rtl/conv_encoder_tx.sv
// conv_encoder_tx: framed rate-1/2 convolutional encoder. Each accepted bit
// yields one 2-bit symbol; every frame is flushed with K-1 zero tail bits so
// the decoder always starts from trellis state 0.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : conv_encoder_tx_if.slave (input bits, output symbols)
//   frame_cnt : frames completed, counted when the last tail symbol loads
//   overflow  : sticky, a frame reached MAX_LEN bits without in_last
module conv_encoder_tx
  import conv_pkg::*;
#(
  parameter int           K       = K_DEF,
  parameter logic [K-1:0] G0      = G0_DEF,
  parameter logic [K-1:0] G1      = G1_DEF,
  parameter int           MAX_LEN = MAX_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst,
  conv_encoder_tx_if.slave    bus,
  output logic [15:0]         frame_cnt,
  output logic                overflow
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int TW = (K > 2) ? $clog2(K) : 1;

  enc_state_t    state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] tail_cnt_q, tail_cnt_d;

  logic       slot_free;   // output register may be (re)loaded this cycle
  logic       accept;
  logic       tail_load;
  logic       load;
  logic       last_tail;
  logic       ovf_set;
  logic [1:0] sym;

  assign slot_free    = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = (state_q != TAIL) && slot_free;
  assign accept       = bus.in_valid && bus.in_ready;
  assign tail_load    = (state_q == TAIL) && slot_free;
  assign load         = accept || tail_load;

  conv_enc_core #(.K(K), .G0(G0), .G1(G1)) u_core (
    .clk  (clk),
    .rst  (rst),
    .clr  (last_tail),
    .load (load),
    .b    ((state_q == TAIL) ? 1'b0 : bus.in_bit),
    .sym  (sym)
  );

  // NOTE: every signal written here gets a default first; a path that
  // skipped an assignment would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tail_cnt_d = tail_cnt_q;
    last_tail  = 1'b0;
    ovf_set    = 1'b0;
    unique case (state_q)
      IDLE, DATA: begin
        if (accept) begin
          bit_cnt_d = (state_q == IDLE) ? CW'(1) : bit_cnt_q + 1'b1;
          // A frame closes on in_last or when it is full; a full frame
          // without in_last is an overflow and later bits open a new frame.
          if (bus.in_last || (bit_cnt_d == CW'(MAX_LEN))) begin
            state_d    = TAIL;
            tail_cnt_d = '0;
            ovf_set    = !bus.in_last;
          end else begin
            state_d = DATA;
          end
        end
      end
      TAIL: begin
        if (tail_load) begin
          if (tail_cnt_q == TW'(K - 2)) begin
            last_tail  = 1'b1;
            state_d    = IDLE;
            bit_cnt_d  = '0;
            tail_cnt_d = '0;
          end else begin
            tail_cnt_d = tail_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      tail_cnt_q    <= '0;
      bus.out_valid <= 1'b0;
      bus.out_sym   <= '0;
      bus.out_last  <= 1'b0;
      frame_cnt     <= '0;
      overflow      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tail_cnt_q <= tail_cnt_d;
      if (ovf_set)   overflow  <= 1'b1;
      if (last_tail) frame_cnt <= frame_cnt + 16'd1;
      // Single output stage: reload whenever the slot is free, otherwise
      // hold the stalled symbol untouched.
      if (load) begin
        bus.out_valid <= 1'b1;
        bus.out_sym   <= sym;
        bus.out_last  <= last_tail;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
        bus.out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_encoder_tx.sv
// tb_conv_encoder_tx: directed plus randomized bench for conv_encoder_tx.
// The reference model encodes each bit as a tap-weighted parity over the
// current bit and the previous K-1 bits of the frame, appends K-1 zero bits
// per frame, and tracks which cycles the encoder must spend in its tail.
module tb_conv_encoder_tx;
  import conv_pkg::*;

  localparam int           K       = 3;
  localparam int           MAX_LEN = 256;
  localparam logic [K-1:0] G0      = 3'b111;
  localparam logic [K-1:0] G1      = 3'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] frame_cnt;
  logic        overflow;

  conv_encoder_tx_if bus ();

  conv_encoder_tx #(.K(K), .G0(G0), .G1(G1), .MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .frame_cnt (frame_cnt),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [K-1:0] g0v = G0;
  logic [K-1:0] g1v = G1;
  bit           hist [K-1];     // hist[0] = most recent bit of this frame
  logic [2:0]   exp_q [$];      // {sym, last} in emission order
  int           frame_len  = 0;
  int           tails_left = 0; // tail symbols still to be loaded
  int           exp_frames = 0;
  bit           exp_ovf    = 0;

  function automatic logic [1:0] ref_sym(input bit b);
    bit x;
    logic p1, p0;
    p1 = 1'b0;
    p0 = 1'b0;
    for (int j = 0; j < K; j++) begin
      x  = (j == 0) ? b : hist[(j > 0) ? j - 1 : 0];
      p1 = p1 ^ (g0v[K-1-j] & x);
      p0 = p0 ^ (g1v[K-1-j] & x);
    end
    return {p1, p0};
  endfunction

  function automatic void model_push(input bit b, input bit last);
    exp_q.push_back({ref_sym(b), last});
    for (int j = K - 2; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = b;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    for (int j = 0; j < K - 1; j++) hist[j] = 1'b0;
    frame_len  = 0;
    tails_left = 0;
    exp_frames = 0;
    exp_ovf    = 0;
  endfunction

  // ---------------- monitor ----------------
  int         cyc = 0;
  int         xfer_cyc [$];
  logic [1:0] obs_syms [$];
  bit         stalled = 0;
  logic [2:0] held;
  logic [2:0] e;
  bit         slot_free;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      model_reset();
      stalled = 0;
    end else begin
      slot_free = !bus.out_valid || bus.out_ready;
      if (stalled) begin
        check("hold_valid", bus.out_valid, 1'b1);
        check("hold_sym_last", {bus.out_sym, bus.out_last}, held);
      end
      check("in_ready", bus.in_ready, (tails_left == 0) && slot_free);
      if (bus.out_valid && bus.out_ready) begin
        check("symbol_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sym_last", {bus.out_sym, bus.out_last}, e);
        end
        xfer_cyc.push_back(cyc);
        obs_syms.push_back(bus.out_sym);
      end
      stalled = bus.out_valid && !bus.out_ready;
      held    = {bus.out_sym, bus.out_last};
      if (tails_left > 0) begin
        if (slot_free) tails_left--;
      end else if (bus.in_valid && bus.in_ready) begin
        model_push(bus.in_bit, 1'b0);
        frame_len++;
        if (bus.in_last || frame_len == MAX_LEN) begin
          if (!bus.in_last) exp_ovf = 1;
          for (int t = 0; t < K - 1; t++) model_push(1'b0, t == K - 2);
          frame_len  = 0;
          tails_left = K - 1;
          exp_frames++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int ready_mode = 0;  // 0: always ready, 1: toggle each cycle, 2: random

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       bus.out_ready = !bus.out_ready;
        2:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send_bit(input bit b, input bit last);
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    bus.in_last  = last;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      if (n == 200) begin
        check("in_ready_timeout", bus.in_ready, 1'b1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    bus.in_valid = 1'b0;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && tails_left == 0 && !bus.out_valid) break;
      if (n == 300) begin
        check("drain_timeout", exp_q.size(), 0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_seq(input string tag, input logic [1:0] exp [$]);
    check({tag, "_len"}, obs_syms.size(), exp.size());
    for (int i = 0; i < exp.size() && i < obs_syms.size(); i++)
      check($sformatf("%s_%0d", tag, i), obs_syms[i], exp[i]);
  endtask

  logic [1:0] seq_1011 [$] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
  logic [1:0] seq_1    [$] = '{2'b11, 2'b10, 2'b11};
  int         len;

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    bus.in_last  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_sym", bus.out_sym, 2'b00);
    check("rst_out_last", bus.out_last, 1'b0);
    check("rst_frame_cnt", frame_cnt, 16'd0);
    check("rst_overflow", overflow, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Frame 1,0,1,1 with a always-ready sink.
    obs_syms.delete();
    send_bit(1, 0); send_bit(0, 0); send_bit(1, 0); send_bit(1, 1);
    wait_drain();
    check_seq("f1011", seq_1011);
    check("frame_cnt_1", frame_cnt, 16'd1);

    // Same frame under 1/0 backpressure.
    ready_mode = 1;
    obs_syms.delete();
    send_bit(1, 0); send_bit(0, 0); send_bit(1, 0); send_bit(1, 1);
    wait_drain();
    check_seq("f1011_stall", seq_1011);
    check("frame_cnt_2", frame_cnt, 16'd2);
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // Single-bit frame.
    obs_syms.delete();
    send_bit(1, 1);
    wait_drain();
    check_seq("f1", seq_1);
    check("frame_cnt_3", frame_cnt, 16'd3);

    // Back-to-back frames: 9 symbols on consecutive cycles.
    xfer_cyc.delete();
    obs_syms.delete();
    send_bit(1, 0); send_bit(0, 0); send_bit(1, 0); send_bit(1, 1);
    send_bit(1, 1);
    wait_drain();
    check("b2b_count", xfer_cyc.size(), 9);
    if (xfer_cyc.size() == 9) check("b2b_span", xfer_cyc[8] - xfer_cyc[0], 8);
    check("frame_cnt_5", frame_cnt, 16'd5);

    // 300 bits without in_last: overflow after bit 256.
    for (int i = 0; i < 300; i++) send_bit(1'($urandom_range(0, 1)), 0);
    check("ovf_set", overflow, 1'b1);
    check("ovf_frame_len", frame_len, 44);
    send_bit(1'($urandom_range(0, 1)), 1);
    wait_drain();
    check("frame_cnt_ovf", frame_cnt, 16'(exp_frames));
    check("frame_cnt_7", frame_cnt, 16'd7);
    check("ovf_sticky", overflow, exp_ovf);

    // Reset two bits into a frame.
    send_bit(1, 0); send_bit(1, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_in_ready", bus.in_ready, 1'b1);
    check("midrst_frame_cnt", frame_cnt, 16'd0);
    check("midrst_overflow", overflow, 1'b0);
    @(posedge clk);
    #1;
    obs_syms.delete();
    send_bit(1, 0); send_bit(0, 0); send_bit(1, 0); send_bit(1, 1);
    wait_drain();
    check_seq("f1011_after_rst", seq_1011);
    check("frame_cnt_after_rst", frame_cnt, 16'd1);

    // Random frames with a random sink.
    ready_mode = 2;
    for (int f = 0; f < 20; f++) begin
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) send_bit(1'($urandom_range(0, 1)), i == len - 1);
    end
    wait_drain();
    check("rand_frame_cnt", frame_cnt, 16'(exp_frames));
    check("rand_frame_cnt_abs", frame_cnt, 16'd21);
    check("rand_overflow", overflow, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
